// File: rtl/priority_irq_ctrl.sv
// priority_irq_ctrl: sticky-request priority encoder, fixed or round-robin, with a held valid/ready grant
module priority_irq_ctrl #(
    parameter int N = 8,
    parameter int RR_MODE = 0,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state_q, state_d;
    logic [N-1:0] pending_q, pending_d, eligible;
    logic [W-1:0] out_idx_q, out_idx_d, ptr_q, ptr_d, sel, k;
    logic accept;
    always_comb begin
        eligible = pending_q & ~mask;
        sel = '0;
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (RR_MODE == 0 && eligible[i]) sel = W'(i);
        end
        // descending from ptr with wrap; iterating far-to-near lets the nearest eligible line win
        for (int j = N - 1; j >= 0; j--) begin
            k = W'((int'(ptr_q) + N - j) % N);
            if (RR_MODE != 0 && eligible[k]) sel = k;
        end
        accept = state_q == GRANT && out_ready;
        pending_d = (pending_q & ~(accept ? N'(1) << out_idx_q : '0)) | req;
        state_d = state_q;
        out_idx_d = out_idx_q;
        ptr_d = ptr_q;
        if (state_q == IDLE && eligible != '0) begin
            state_d = GRANT;
            out_idx_d = sel;
        end
        if (accept) begin
            state_d = IDLE;
            ptr_d = RR_MODE != 0 ? (out_idx_q == '0 ? W'(N - 1) : out_idx_q - 1'b1) : ptr_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pending_q <= '0;
            out_idx_q <= '0;
            ptr_q <= W'(N - 1);
        end else begin
            state_q <= state_d;
            pending_q <= pending_d;
            out_idx_q <= out_idx_d;
            ptr_q <= ptr_d;
        end
    end
    assign out_valid = state_q == GRANT;
    assign out_idx = out_idx_q;
    assign pending = pending_q;
endmodule

// File: tb/tb_priority_irq_ctrl.sv
// tb_priority_irq_ctrl: fixed N=8 and round-robin N=4 instances checked against a behavioural model
module tb_priority_irq_ctrl;
    logic clk = 0;
    always #5 clk = ~clk;
    logic rst0 = 1, rst1 = 1, rdy0 = 0, rdy1 = 0;
    logic [7:0] req0 = 0, mask0 = 0, pend0;
    logic [3:0] req1 = 0, mask1 = 0, pend1;
    logic v0, v1;
    logic [2:0] idx0;
    logic [1:0] idx1;
    int total = 0, bad = 0, cyc = 0;
    bit armed = 0;
    int log0[$], log1[$], t0[$], e[$];

    priority_irq_ctrl #(.N(8), .RR_MODE(0)) d0 (.clk(clk), .rst(rst0), .req(req0), .mask(mask0),
        .out_ready(rdy0), .out_valid(v0), .out_idx(idx0), .pending(pend0));
    priority_irq_ctrl #(.N(4), .RR_MODE(1)) d1 (.clk(clk), .rst(rst1), .req(req1), .mask(mask1),
        .out_ready(rdy1), .out_valid(v1), .out_idx(idx1), .pending(pend1));

    typedef struct {logic [7:0] pend; logic v; int idx; int ptr;} ms_t;
    ms_t m0, m1;

    function automatic ms_t step_m(ms_t s, int n, bit rr, logic [7:0] rq, logic [7:0] mk, logic rdy, logic rs);
        ms_t r = s;
        logic [7:0] nm = 8'((1 << n) - 1);
        logic [7:0] el = s.pend & ~mk & nm;
        if (rs) begin
            r.pend = 0; r.v = 0; r.idx = 0; r.ptr = n - 1;
            return r;
        end
        r.pend = s.pend | (rq & nm);
        if (s.v) begin
            if (rdy) begin
                if (!rq[s.idx]) r.pend[s.idx] = 0;
                r.v = 0;
                if (rr) r.ptr = (s.idx + n - 1) % n;
            end
        end else if (el != 0) begin
            r.v = 1;
            if (rr) begin
                for (int j = 0; j < n; j++)
                    if (el[(s.ptr - j + n) % n]) begin r.idx = (s.ptr - j + n) % n; break; end
            end else begin
                for (int q = n - 1; q >= 0; q--)
                    if (el[q]) begin r.idx = q; break; end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m0 <= step_m(m0, 8, 0, req0, mask0, rdy0, rst0);
        m1 <= step_m(m1, 4, 1, {4'b0, req1}, {4'b0, mask1}, rdy1, rst1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("v0", 32'(v0), 32'(m0.v));
            chk("idx0", 32'(idx0), m0.idx);
            chk("pend0", 32'(pend0), 32'(m0.pend));
            chk("v1", 32'(v1), 32'(m1.v));
            chk("idx1", 32'(idx1), m1.idx);
            chk("pend1", 32'(pend1), 32'(m1.pend));
            if (v0 && rdy0) begin log0.push_back(int'(idx0)); t0.push_back(cyc); end
            if (v1 && rdy1) log1.push_back(int'(idx1));
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_log(input string nm, input int lg[$], input int ex[$]);
        chk({nm, "_len"}, lg.size(), ex.size());
        for (int i = 0; i < ex.size() && i < lg.size(); i++) chk(nm, lg[i], ex[i]);
    endtask

    task automatic wait_v0();
        int n = 0;
        while (!v0 && n < 20) begin step(); n++; end
        chk("wait_v0", 32'(v0), 1);
    endtask

    task automatic wait_v1();
        int n = 0;
        while (!v1 && n < 20) begin step(); n++; end
        chk("wait_v1", 32'(v1), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(); step();
        armed = 1;
        chk("rst_v", 32'(v0), 0);
        chk("rst_idx", 32'(idx0), 0);
        chk("rst_pend", 32'(pend0), 0);
        rst0 = 0; rst1 = 0;
        repeat (10) step();
        chk("idle_v", 32'(v0), 0);
        chk("idle_pend", 32'(pend0), 0);
        // fixed priority drain
        rdy0 = 1; req0 = 8'b10000101; step(); req0 = 0;
        repeat (8) step();
        e = '{7, 2, 0}; chk_log("fix", log0, e);
        if (t0.size() == 3) begin
            chk("gap1", t0[1] - t0[0], 2);
            chk("gap2", t0[2] - t0[1], 2);
        end
        chk("fix_pend", 32'(pend0), 0);
        // backpressure
        log0.delete(); rdy0 = 0; req0 = 8'h10; step(); req0 = 0;
        wait_v0();
        for (int i = 0; i < 5; i++) begin
            chk("bp_v", 32'(v0), 1);
            chk("bp_idx", 32'(idx0), 4);
            req0 = (i == 1) ? 8'h40 : 8'h00;
            step();
        end
        rdy0 = 1; repeat (6) step();
        e = '{4, 6}; chk_log("bp", log0, e);
        // masking
        log0.delete(); mask0 = 8'h80; req0 = 8'hC0; step(); req0 = 0;
        repeat (6) step();
        e = '{6}; chk_log("mask", log0, e);
        chk("mask_p7", 32'(pend0[7]), 1);
        mask0 = 0; repeat (4) step();
        e = '{6, 7}; chk_log("unmask", log0, e);
        log0.delete(); mask0 = 8'hFF; req0 = 8'h03; step(); req0 = 0;
        for (int i = 0; i < 6; i++) begin chk("allmask_v", 32'(v0), 0); step(); end
        chk("allmask_pend", 32'(pend0), 3);
        mask0 = 0; repeat (8) step();
        e = '{1, 0}; chk_log("drain", log0, e);
        // reset mid-grant
        rdy0 = 0; req0 = 8'h20; step(); req0 = 0;
        wait_v0();
        rdy0 = 1; rst0 = 1; step(); rst0 = 0;
        chk("mrst_v", 32'(v0), 0);
        chk("mrst_pend", 32'(pend0), 0);
        log0.delete(); req0 = 8'h09; step(); req0 = 0;
        repeat (8) step();
        e = '{3, 0}; chk_log("post_rst", log0, e);
        // round-robin, continuous requests
        rdy1 = 1; req1 = 4'hF;
        for (int n = 0; n < 40 && log1.size() < 6; n++) step();
        e = '{3, 2, 1, 0, 3, 2}; chk_log("rr", log1, e);
        chk("rr_pend", 32'(pend1), 32'hF);
        for (int n = 0; n < 40 && log1.size() < 7; n++) step();
        rdy1 = 0; wait_v1();
        rdy1 = 1; rst1 = 1; step(); rst1 = 0;
        chk("rr_rst_v", 32'(v1), 0);
        chk("rr_rst_pend", 32'(pend1), 0);
        log1.delete();
        for (int n = 0; n < 40 && log1.size() < 2; n++) step();
        e = '{3, 2}; chk_log("rr_post_rst", log1, e);
        req1 = 0;
        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            req0 = 8'($urandom) & 8'($urandom) & 8'($urandom);
            mask0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rdy0 = 1'($urandom_range(0, 1));
            rst0 = $urandom_range(0, 199) == 0;
            req1 = 4'($urandom) & 4'($urandom);
            mask1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rdy1 = 1'($urandom_range(0, 1));
            rst1 = $urandom_range(0, 199) == 0;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/priority_irq_ctrl.md
# priority_irq_ctrl

Parametrised, registered priority encoder with sticky request capture, per-line masking, a valid/ready grant handshake and selectable fixed or round-robin priority. It is the next generation of the combinational 8-line priority encoder. It turns N asynchronous-in-meaning request lines into a stream of encoded indices that a downstream consumer acknowledges one at a time. Its typical use is as an interrupt or request controller in front of a single serviced resource.

## Interface
- N, default 8, number of request lines (N >= 2)
- RR_MODE, default 0, 0 = fixed priority (highest index wins), 1 = round-robin
- W (localparam) = $clog2(N), width of the encoded index
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N  request lines, sampled every cycle; a high bit sets the matching pending bit
- mask  input  N  1 = line excluded from selection (pending bit still kept)
- out_ready  input  1  consumer accepts the current grant
- out_valid  output  1  a grant is presented
- out_idx  output  W  encoded index of the granted line
- pending  output  N  registered sticky request state

## Operation
- pending_next = (pending | req), with the granted bit cleared on accept.
  - Clear applies only when out_valid && out_ready: pending[out_idx] <= 0.
  - If req[out_idx] is high in the same cycle, the set wins and the bit stays 1.
- eligible = pending & ~mask. It uses the registered pending only; req does not bypass into the current cycle.
- Selection, fixed (RR_MODE=0): the highest set index of eligible, identical ordering to the 8-line encoder (bit N-1 highest, bit 0 lowest).
- Selection, round-robin (RR_MODE=1):
  - Search starts at ptr and goes descending with wrap (ptr, ptr-1, ..., 0, N-1, ..., ptr+1).
  - The first eligible bit wins.
  - After an accepted grant of index k, ptr <= (k == 0) ? N-1 : k-1.
  - ptr does not change in fixed mode.
- State machine, two states:
  - IDLE:
    - If eligible != 0, register out_idx <= selected index and out_valid <= 1, then go to GRANT.
    - Otherwise stay, with out_valid = 0.
  - GRANT:
    - out_valid = 1 and out_idx is held stable.
    - On out_ready, clear the pending bit, update ptr, set out_valid <= 0 and go to IDLE.
    - Without out_ready, stay. A grant is never retracted or changed, even if its line becomes masked or a higher-priority request arrives.
- Throughput is at most one grant per two cycles: the GRANT cycle plus an IDLE reselect cycle.
- All N bits set and none masked: grants issue in order N-1, N-2, ..., 0 in fixed mode, and in the same order in RR mode from reset.
- eligible == 0 while pending != 0 (all pending lines masked): stay in IDLE. Unmasking makes a line selectable on the next IDLE evaluation.

## Timing
- Reset values: pending = 0, out_valid = 0, out_idx = 0, ptr = N-1, state = IDLE.
  - Reset has priority over every other event, including a grant accepted in the same cycle.
  - A mid-handshake reset drops the grant and all pending bits.
- Latency:
  - req high before edge t sets pending after edge t.
  - The IDLE evaluation during cycle t+1 gives out_valid = 1 after edge t+1, i.e. two edges from req to out_valid.
- Accept: with out_valid && out_ready at edge e, out_valid = 0 after e, and the next grant (if any) is valid after e+1.
- out_ready while out_valid = 0 is ignored.
- mask and out_ready are sampled only at rising edges, with no combinational path to outputs.
- All outputs are registered.

## Test plan
- Reset and idle:
  - Stimulus: rst for 2 cycles, req = 0.
  - Required: out_valid = 0, out_idx = 0, pending = 0; stays idle for 10 cycles.
- Fixed priority, N=8, RR_MODE=0:
  - Stimulus: one-cycle pulse req = 8'b10000101, out_ready held 1.
  - Required: grants 7, 2, 0 on successive handshakes, spaced 2 cycles apart; pending returns to 0.
- Backpressure and stability:
  - Stimulus: req = 8'b00010000 pulse, out_ready = 0 for 5 cycles, req = 8'b01000000 pulse during the wait, then out_ready = 1.
  - Required: out_idx stays 4 with out_valid high throughout the wait; after accept the next grant is 6.
- Masking:
  - Stimulus: req = 8'b11000000, mask = 8'b10000000.
  - Required: first grant is 6; pending[7] stays 1; after mask clears, next grant is 7.
  - Stimulus: mask = 8'hFF with pending nonzero.
  - Required: out_valid stays 0.
- Round-robin, N=4, RR_MODE=1:
  - Stimulus: req = 4'b1111 held high continuously, out_ready = 1.
  - Required: grant sequence 3, 2, 1, 0, 3, 2, ...; pending stays 4'b1111 because the same-cycle set wins.
- Reset mid-grant:
  - Stimulus: assert rst while out_valid = 1 and out_ready = 1.
  - Required: after the edge, out_valid = 0, pending = 0, ptr = N-1; the next request after reset is granted by the fixed order.
